// File: rtl/rom_line_fetch.sv
// rom_line_fetch: single-line read buffer between a halfword-addressed core
// port and a line-wide memory. A hit returns data one cycle after the strobe.
// A miss fetches the whole line, stores it in the buffer, and returns the
// requested halfword.
module rom_line_fetch #(
    parameter int AW = 20,
    parameter int LW = 64
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            rom_rd,
    input  logic [AW-1:0]   rom_a,
    output logic [15:0]     rom_do,
    output logic            rom_rdy,
    output logic            busy,
    input  logic            inv,
    output logic            mem_req,
    output logic [AW-3:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [LW-1:0]   mem_dout,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     miss_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIT  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [LW-1:0] r_line;
    logic [AW-3:0] r_tag;
    logic          r_valid;
    logic [1:0]    r_off;
    logic [AW-3:0] r_mem_addr;
    logic [15:0]   r_rom_do;
    logic          r_rom_rdy;
    logic          r_busy;
    logic          r_mem_req;
    logic [15:0]   r_hit_cnt;
    logic [15:0]   r_miss_cnt;

    logic [1:0]    w_next;
    logic          w_hit;
    logic          w_accept;
    logic          w_fill_ack;

    // Pick halfword 'off' out of a buffered or returned line.
    function automatic logic [15:0] sel_hw(input logic [LW-1:0] line, input logic [1:0] off);
        logic [15:0] hw;
        case (off)
            2'd0:    hw = line[15:0];
            2'd1:    hw = line[31:16];
            2'd2:    hw = line[47:32];
            2'd3:    hw = line[63:48];
            default: hw = line[15:0];
        endcase
        return hw;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && rom_rd;
    assign w_fill_ack = (r_state == S_FILL) && mem_ack;

    // Hit/miss decision and next state. An invalidate in the same cycle makes
    // the buffer unusable, so that request is treated as a miss.
    always_comb begin
        w_hit  = r_valid && !inv && (r_tag == rom_a[AW-1:2]);
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rom_rd) begin
                    w_next = w_hit ? S_HIT : S_FILL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_HIT:  w_next = S_IDLE;
            S_FILL: begin
                if (mem_ack) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, buffer, counters and registered outputs. The outputs are derived
    // from the next state so that they are aligned with the state they describe.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_line     <= '0;
            r_tag      <= '0;
            r_valid    <= 1'b0;
            r_off      <= 2'd0;
            r_mem_addr <= '0;
            r_rom_do   <= 16'h0000;
            r_rom_rdy  <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_hit_cnt  <= 16'h0000;
            r_miss_cnt <= 16'h0000;
        end else begin
            r_state   <= w_next;
            r_rom_rdy <= (w_next == S_HIT) || (w_next == S_DONE);
            r_busy    <= (w_next != S_IDLE);
            r_mem_req <= (w_next == S_FILL);

            // Invalidate wins over a fill completing in the same cycle.
            if (inv) begin
                r_valid <= 1'b0;
            end else if (w_fill_ack) begin
                r_valid <= 1'b1;
            end else begin
                r_valid <= r_valid;
            end

            if (w_accept) begin
                r_off      <= rom_a[1:0];
                r_mem_addr <= rom_a[AW-1:2];
                if (w_hit) begin
                    r_rom_do <= sel_hw(r_line, rom_a[1:0]);
                end else begin
                    r_rom_do <= r_rom_do;
                end
            end else if (w_fill_ack) begin
                r_line     <= mem_dout;
                r_tag      <= r_mem_addr;
                r_rom_do   <= sel_hw(mem_dout, r_off);
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end else if (r_state == S_HIT) begin
                r_hit_cnt  <= sat_inc(r_hit_cnt);
            end else begin
                r_rom_do   <= r_rom_do;
            end
        end
    end

    assign rom_do   = r_rom_do;
    assign rom_rdy  = r_rom_rdy;
    assign busy     = r_busy;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_rom_line_fetch.sv
// Bench for rom_line_fetch: directed hit/miss sequences. Expected read data
// is queued at issue time and checked by an independent monitor on rom_rdy.
module tb_rom_line_fetch;

    localparam int AW = 20;
    localparam int LW = 64;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b1;
    logic            rom_rd  = 1'b0;
    logic [AW-1:0]   rom_a   = '0;
    logic [15:0]     rom_do;
    logic            rom_rdy;
    logic            busy;
    logic            inv     = 1'b0;
    logic            mem_req;
    logic [AW-3:0]   mem_addr;
    logic            mem_ack = 1'b0;
    logic [LW-1:0]   mem_dout = '0;
    logic [15:0]     hit_cnt;
    logic [15:0]     miss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    rom_line_fetch #(.AW(AW), .LW(LW)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .rom_rd  (rom_rd),
        .rom_a   (rom_a),
        .rom_do  (rom_do),
        .rom_rdy (rom_rdy),
        .busy    (busy),
        .inv     (inv),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .mem_ack (mem_ack),
        .mem_dout(mem_dout),
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge sys_clk) begin
        if (!reset && rom_rdy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rdy_unexpected: got rom_rdy with rom_do=%0h expected no completion at %0t", rom_do, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rom_do !== e) begin
                    n_err++;
                    $display("FAIL rom_do: got %0h expected %0h at %0t", rom_do, e, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Strobe rom_rd for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [AW-1:0] a);
        rom_rd = 1'b1;
        rom_a  = a;
        step();
        rom_rd = 1'b0;
    endtask

    task automatic do_hit(input logic [AW-1:0] a, input logic [15:0] exp_do, input logic [15:0] exp_hits);
        exp_q.push_back(exp_do);
        issue(a);
        chk("hit_rdy", 64'(rom_rdy), 64'd1);
        chk("hit_no_req", 64'(mem_req), 64'd0);
        step();
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
    endtask

    // Miss: mem_ack comes in the w-th cycle of mem_req. Optionally invalidate
    // together with the ack, or fire a stray rom_rd during the fill.
    task automatic do_miss(input logic [AW-1:0] a, input logic [AW-3:0] exp_addr,
                           input logic [63:0] line, input int w, input bit inv_ack,
                           input bit alt_rd, input logic [15:0] exp_do, input logic [15:0] exp_miss);
        exp_q.push_back(exp_do);
        issue(a);
        for (int k = 0; k < w; k++) begin
            chk("fill_req", 64'(mem_req), 64'd1);
            chk("fill_addr", 64'(mem_addr), 64'(exp_addr));
            chk("fill_busy", 64'(busy), 64'd1);
            if (k == w - 1) begin
                mem_ack  = 1'b1;
                mem_dout = line;
                inv      = inv_ack;
            end else if (alt_rd && k == 1) begin
                rom_rd = 1'b1;
                rom_a  = 20'h00020;
            end
            step();
            mem_ack = 1'b0;
            inv     = 1'b0;
            rom_rd  = 1'b0;
            rom_a   = a;
        end
        chk("done_rdy", 64'(rom_rdy), 64'd1);
        chk("done_req_low", 64'(mem_req), 64'd0);
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        step();
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_rdy", 64'(rom_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_do", 64'(rom_do), 64'd0);
        chk("rst_hits", 64'(hit_cnt), 64'd0);
        chk("rst_miss", 64'(miss_cnt), 64'd0);

        // First miss, then hit in the same line.
        do_miss(20'h00005, 18'h00001, 64'h4444_3333_2222_1111, 3, 1'b0, 1'b0, 16'h2222, 16'd1);
        do_hit(20'h00007, 16'h4444, 16'd1);

        // Invalidate in idle, then the same line must be fetched again.
        inv = 1'b1;
        step();
        inv = 1'b0;
        do_miss(20'h00004, 18'h00001, 64'h8888_7777_6666_5555, 2, 1'b0, 1'b0, 16'h5555, 16'd2);

        // Invalidate together with rom_rd: a would-be hit becomes a miss.
        inv = 1'b1;
        do_miss(20'h00006, 18'h00001, 64'hAAAA_BBBB_CCCC_DDDD, 2, 1'b0, 1'b0, 16'hBBBB, 16'd3);

        // Stray rom_rd during the fill is ignored.
        do_miss(20'h00010, 18'h00004, 64'h0123_4567_89AB_CDEF, 4, 1'b0, 1'b1, 16'hCDEF, 16'd4);
        step();
        step();

        // Invalidate with mem_ack: data still returned, line left invalid.
        do_miss(20'h00021, 18'h00008, 64'h1357_9BDF_2468_ACE0, 2, 1'b1, 1'b0, 16'h2468, 16'd5);
        do_miss(20'h00021, 18'h00008, 64'hFFFF_EEEE_DDDD_CCCC, 1, 1'b0, 1'b0, 16'hDDDD, 16'd6);

        // mem_ack outside a fill must not disturb the buffer or counters.
        mem_ack  = 1'b1;
        mem_dout = 64'h9999_9999_9999_9999;
        step();
        mem_ack  = 1'b0;
        chk("stray_ack_rdy", 64'(rom_rdy), 64'd0);
        do_hit(20'h00022, 16'hEEEE, 16'd2);
        chk("stray_ack_miss", 64'(miss_cnt), 64'd6);

        // Reset in the middle of a fill aborts it.
        issue(20'h00030);
        chk("abort_req", 64'(mem_req), 64'd1);
        step();
        reset = 1'b1;
        rom_rd = 1'b1;
        step();
        reset  = 1'b0;
        rom_rd = 1'b0;
        chk("abort_req_low", 64'(mem_req), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_miss", 64'(miss_cnt), 64'd0);
        mem_ack  = 1'b1;
        mem_dout = 64'h7777_7777_7777_7777;
        step();
        mem_ack = 1'b0;
        chk("late_ack_rdy", 64'(rom_rdy), 64'd0);
        step();
        chk("late_ack_rdy2", 64'(rom_rdy), 64'd0);
        do_miss(20'h00030, 18'h0000C, 64'h5A5A_6B6B_7C7C_8D8D, 2, 1'b0, 1'b0, 16'h8D8D, 16'd1);

        // Hit counter saturation.
        force dut.r_hit_cnt = 16'hFFFE;
        #1;
        release dut.r_hit_cnt;
        chk("hits_forced", 64'(hit_cnt), 64'hFFFE);
        do_hit(20'h00031, 16'h7C7C, 16'hFFFF);
        do_hit(20'h00033, 16'h5A5A, 16'hFFFF);
        do_hit(20'h00032, 16'h6B6B, 16'hFFFF);

        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
